car_sequencer: RTL and testbench
================================

CAR_SEQUENCER -- requirements
Module: car_sequencer

Interface
REQ-001 SHALL have port MCLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port MDB_in, input, 16 bits: memory data bus, carrying the next instruction word during fetch states.
REQ-004 SHALL have port SR_flags, input, 4 bits: {V,N,Z,C} from the status register.
REQ-005 SHALL have port INTREQ, input, 1 bit: pending maskable or NMI request from the interrupt unit; held until INTACK.
REQ-006 SHALL have port STALL, input, 1 bit: freeze request; present only with CAR_SEQ_STALL_EN.
REQ-007 SHALL have port CAR, output, CAR_BITS bits: control address fed to the control unit.
REQ-008 SHALL have port IR, output, 16 bits: instruction register fed to the control unit.

Function
REQ-009 SHALL define the fetch set F = {CAR_0, REG_REG, REG_IDX3, IND_REG1, IND_IDX4, IDX_REG2, IDX_IDX5, 1OP_REG, 1OP_IND2, 1OP_IDX3, PUSH_REG2, PUSH_IND2, PUSH_IDX3}.
REQ-010 SHALL, in any F state with INTREQ=1, go to CAR_INT0 and hold IR.
REQ-011 SHALL, in any F state with INTREQ=0, load IR <= MDB_in and CAR <= dispatch(MDB_in) on the same edge (single-cycle dispatch latency).
REQ-012 SHALL, in every non-F state, advance linearly to the next state of its chain (e.g. IDX_IDX0->1->2->3->4->5); IR SHALL hold.
REQ-013 SHALL send CALL_REG2, CALL_IND2, CALL_IDX3, RETI3, JMP0 and INT4 unconditionally to CAR_0.
REQ-014 SHALL sample INTREQ only in F states; INT0..INT4 SHALL NOT be re-entered or aborted mid-sequence.
REQ-015 SHALL dispatch Format I (MDB[15:12] >= 4) on source mode {REG, IDX, IND} x dest mode {REG, IDX} to the first state of REG_REG, REG_IDX, IND_REG, IND_IDX, IDX_REG or IDX_IDX.
REQ-016 SHALL classify source mode as: As=00 -> REG; As=01 -> IDX; As=1x -> IND.
REQ-017 SHALL classify a constant-generator source (src=R3 any As, or src=R2 with As=1x) as REG; R2 with As=01 (absolute) SHALL stay IDX.
REQ-018 SHALL dispatch Format II (MDB[15:12]=1) on MDB[9:7]: 000-011 -> 1OP_*; 100 -> PUSH_*; 101 -> CALL_*; 110 -> RETI0; 111 -> CAR_0 (NOP, IR still loaded). Mode SHALL be taken from As and MDB[3:0] with the REQ-017 rule.
REQ-019 SHALL dispatch jumps (MDB[15:13]=001) to CAR_JMP0 if the condition MDB[12:10] is true on the current SR_flags, else to CAR_0.
REQ-020 SHALL use these jump conditions: 000 Z=0; 001 Z=1; 010 C=0; 011 C=1; 100 N=1; 101 N^V=0; 110 N^V=1; 111 always.
REQ-021 SHALL map MDB[15:12]=0 (extended, unsupported) to CAR_0 with IR loaded.
REQ-022 SHALL send any undefined CAR encoding to CAR_0 on the next edge.

Reset
REQ-023 SHALL, while RST_n=0, immediately force CAR=CAR_0 and IR=16'h0000, independent of MCLK.
REQ-024 SHALL, on the first edge after deassertion, treat CAR_0 as a normal fetch state (REQ-010/011); reset mid-sequence SHALL abandon the sequence with no other side effect.

Configuration
REQ-025 SHALL, with CAR_SEQ_STALL_EN defined, hold CAR and IR while STALL=1; STALL SHALL override INTREQ and dispatch, and a held INTREQ SHALL be taken on the first unstalled F edge.
REQ-026 SHALL, without CAR_SEQ_STALL_EN, omit the STALL port and never stall.

Structure
REQ-027 SHALL take the CAR_* encodings, CAR_BITS, SP/SR/PC indices and the jump condition codes from the shared PARAMS package; no local redefinition.
REQ-028 SHALL place dispatch in a combinational sub-module car_decode (MDB_in, SR_flags -> next CAR); car_sequencer holds the registers, F-set test, chains and interrupt entry.

Verification
REQ-029 SHALL cover: reset, then MDB=0x4405 (MOV R4,R5) in CAR_0 -> IR=0x4405, CAR=REG_REG; then MDB=0x5435 -> IND_REG0, IND_REG1.
REQ-030 SHALL cover: MDB=0x4485 (MOV R4,2(R5)) -> REG_IDX0..3 on consecutive edges, then dispatch from REG_IDX3; MDB=0x4325 (constant source) -> REG_REG.
REQ-031 SHALL cover: MDB=0x2405 (JEQ): Z=1 -> JMP0 then CAR_0; Z=0 -> CAR_0. MDB=0x3805 (JL) with N=1, V=0 -> JMP0.
REQ-032 SHALL cover: MDB=0x1284 (CALL R4) -> CALL_REG0..2 then CAR_0; MDB=0x1300 (RETI) -> RETI0..3 then CAR_0.
REQ-033 SHALL cover: INTREQ=1 during IDX_IDX2 -> chain completes to IDX_IDX5, then INT0..INT4 with IR unchanged, then CAR_0.
REQ-034 SHALL cover: RST_n pulsed low mid-IND_IDX1 -> CAR_0 and IR=0 asynchronously; with CAR_SEQ_STALL_EN, 3 STALL cycles in PUSH_IND1 -> CAR held 3 cycles.

Source files
------------

// File: rtl/car_sequencer_pkg.sv
// Shared definitions for the control-address sequencer: CAR encodings,
// register indices, jump condition codes and source-mode classification.
package car_sequencer_pkg;

    localparam int CAR_BITS = 6;

    // Register-file indices with special meaning to the addressing modes.
    localparam logic [3:0] PC_IDX = 4'd0;
    localparam logic [3:0] SP_IDX = 4'd1;
    localparam logic [3:0] SR_IDX = 4'd2;
    localparam logic [3:0] CG_IDX = 4'd3;

    // Jump condition codes carried in instruction bits [12:10].
    localparam logic [2:0] JC_NE = 3'b000;
    localparam logic [2:0] JC_EQ = 3'b001;
    localparam logic [2:0] JC_NC = 3'b010;
    localparam logic [2:0] JC_C  = 3'b011;
    localparam logic [2:0] JC_N  = 3'b100;
    localparam logic [2:0] JC_GE = 3'b101;
    localparam logic [2:0] JC_L  = 3'b110;
    localparam logic [2:0] JC_MP = 3'b111;

    // Control addresses; each multi-cycle chain occupies consecutive codes.
    // Codes 60..63 are unused and recover to CAR_0.
    typedef enum logic [CAR_BITS-1:0] {
        CAR_0          = 6'd0,
        CAR_REG_REG    = 6'd1,
        CAR_REG_IDX0   = 6'd2,
        CAR_REG_IDX1   = 6'd3,
        CAR_REG_IDX2   = 6'd4,
        CAR_REG_IDX3   = 6'd5,
        CAR_IND_REG0   = 6'd6,
        CAR_IND_REG1   = 6'd7,
        CAR_IND_IDX0   = 6'd8,
        CAR_IND_IDX1   = 6'd9,
        CAR_IND_IDX2   = 6'd10,
        CAR_IND_IDX3   = 6'd11,
        CAR_IND_IDX4   = 6'd12,
        CAR_IDX_REG0   = 6'd13,
        CAR_IDX_REG1   = 6'd14,
        CAR_IDX_REG2   = 6'd15,
        CAR_IDX_IDX0   = 6'd16,
        CAR_IDX_IDX1   = 6'd17,
        CAR_IDX_IDX2   = 6'd18,
        CAR_IDX_IDX3   = 6'd19,
        CAR_IDX_IDX4   = 6'd20,
        CAR_IDX_IDX5   = 6'd21,
        CAR_OP1_REG    = 6'd22,
        CAR_OP1_IND0   = 6'd23,
        CAR_OP1_IND1   = 6'd24,
        CAR_OP1_IND2   = 6'd25,
        CAR_OP1_IDX0   = 6'd26,
        CAR_OP1_IDX1   = 6'd27,
        CAR_OP1_IDX2   = 6'd28,
        CAR_OP1_IDX3   = 6'd29,
        CAR_PUSH_REG0  = 6'd30,
        CAR_PUSH_REG1  = 6'd31,
        CAR_PUSH_REG2  = 6'd32,
        CAR_PUSH_IND0  = 6'd33,
        CAR_PUSH_IND1  = 6'd34,
        CAR_PUSH_IND2  = 6'd35,
        CAR_PUSH_IDX0  = 6'd36,
        CAR_PUSH_IDX1  = 6'd37,
        CAR_PUSH_IDX2  = 6'd38,
        CAR_PUSH_IDX3  = 6'd39,
        CAR_CALL_REG0  = 6'd40,
        CAR_CALL_REG1  = 6'd41,
        CAR_CALL_REG2  = 6'd42,
        CAR_CALL_IND0  = 6'd43,
        CAR_CALL_IND1  = 6'd44,
        CAR_CALL_IND2  = 6'd45,
        CAR_CALL_IDX0  = 6'd46,
        CAR_CALL_IDX1  = 6'd47,
        CAR_CALL_IDX2  = 6'd48,
        CAR_CALL_IDX3  = 6'd49,
        CAR_RETI0      = 6'd50,
        CAR_RETI1      = 6'd51,
        CAR_RETI2      = 6'd52,
        CAR_RETI3      = 6'd53,
        CAR_JMP0       = 6'd54,
        CAR_INT0       = 6'd55,
        CAR_INT1       = 6'd56,
        CAR_INT2       = 6'd57,
        CAR_INT3       = 6'd58,
        CAR_INT4       = 6'd59
    } car_t;

    typedef enum logic [1:0] {
        MODE_REG = 2'd0,
        MODE_IDX = 2'd1,
        MODE_IND = 2'd2
    } mode_t;

    // Constant-generator encodings (R3 always, R2 with As=1x) behave as
    // register sources; R2 with As=01 is absolute and stays indexed.
    function automatic mode_t src_mode(input logic [1:0] as_bits, input logic [3:0] src_reg);
        mode_t m;
        if (src_reg == CG_IDX || (src_reg == SR_IDX && as_bits[1])) begin
            m = MODE_REG;
        end else if (as_bits == 2'b00) begin
            m = MODE_REG;
        end else if (as_bits == 2'b01) begin
            m = MODE_IDX;
        end else begin
            m = MODE_IND;
        end
        return m;
    endfunction

    // States at which the next instruction word is fetched (or an interrupt taken).
    function automatic logic is_fetch(input car_t c);
        return c inside {CAR_0, CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4,
                         CAR_IDX_REG2, CAR_IDX_IDX5, CAR_OP1_REG, CAR_OP1_IND2,
                         CAR_OP1_IDX3, CAR_PUSH_REG2, CAR_PUSH_IND2, CAR_PUSH_IDX3};
    endfunction

endpackage

// File: rtl/car_sequencer_if.sv
// Bus between the instruction memory / status register / interrupt unit and
// the control-address sequencer. STALL exists only with CAR_SEQ_STALL_EN.
interface car_sequencer_if;
    import car_sequencer_pkg::*;

    logic [15:0]         MDB_in;
    logic [3:0]          SR_flags;
    logic                INTREQ;
`ifdef CAR_SEQ_STALL_EN
    logic                STALL;
`endif
    logic [CAR_BITS-1:0] CAR;
    logic [15:0]         IR;

    modport master (
        output MDB_in,
        output SR_flags,
        output INTREQ,
`ifdef CAR_SEQ_STALL_EN
        output STALL,
`endif
        input  CAR,
        input  IR
    );

    modport slave (
        input  MDB_in,
        input  SR_flags,
        input  INTREQ,
`ifdef CAR_SEQ_STALL_EN
        input  STALL,
`endif
        output CAR,
        output IR
    );

endinterface

// File: rtl/car_decode.sv
// Combinational instruction dispatch: maps the fetched word and the current
// status flags ({V,N,Z,C}) to the first control address of its sequence.
module car_decode
    import car_sequencer_pkg::*;
(
    input  logic [15:0] MDB_in,
    input  logic [3:0]  SR_flags,
    output car_t        next_car
);

    mode_t fmt1_mode;
    mode_t fmt2_mode;
    logic  jump_taken;

    function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
        logic v, n, z, c, r;
        {v, n, z, c} = flags;
        case (cond)
            JC_NE:   r = !z;
            JC_EQ:   r = z;
            JC_NC:   r = !c;
            JC_C:    r = c;
            JC_N:    r = n;
            JC_GE:   r = !(n ^ v);
            JC_L:    r = n ^ v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign fmt1_mode  = src_mode(MDB_in[5:4], MDB_in[11:8]);
    assign fmt2_mode  = src_mode(MDB_in[5:4], MDB_in[3:0]);
    assign jump_taken = cond_true(MDB_in[12:10], SR_flags);

    // Select the entry state by instruction format, operation and addressing mode.
    always_comb begin
        next_car = CAR_0;
        if (MDB_in[15:12] >= 4'd4) begin
            case (fmt1_mode)
                MODE_REG: next_car = MDB_in[7] ? CAR_REG_IDX0 : CAR_REG_REG;
                MODE_IDX: next_car = MDB_in[7] ? CAR_IDX_IDX0 : CAR_IDX_REG0;
                default:  next_car = MDB_in[7] ? CAR_IND_IDX0 : CAR_IND_REG0;
            endcase
        end else if (MDB_in[15:13] == 3'b001) begin
            next_car = jump_taken ? CAR_JMP0 : CAR_0;
        end else if (MDB_in[15:12] == 4'd1) begin
            case (MDB_in[9:7])
                3'b000, 3'b001, 3'b010, 3'b011: begin
                    case (fmt2_mode)
                        MODE_REG: next_car = CAR_OP1_REG;
                        MODE_IDX: next_car = CAR_OP1_IDX0;
                        default:  next_car = CAR_OP1_IND0;
                    endcase
                end
                3'b100: begin
                    case (fmt2_mode)
                        MODE_REG: next_car = CAR_PUSH_REG0;
                        MODE_IDX: next_car = CAR_PUSH_IDX0;
                        default:  next_car = CAR_PUSH_IND0;
                    endcase
                end
                3'b101: begin
                    case (fmt2_mode)
                        MODE_REG: next_car = CAR_CALL_REG0;
                        MODE_IDX: next_car = CAR_CALL_IDX0;
                        default:  next_car = CAR_CALL_IND0;
                    endcase
                end
                3'b110:  next_car = CAR_RETI0;
                default: next_car = CAR_0;
            endcase
        end
    end

endmodule

// File: rtl/car_sequencer.sv
// Control-address sequencer: holds CAR and IR, dispatches a new instruction
// in fetch states, walks multi-cycle chains and enters the interrupt
// sequence. Optional freeze input is enabled with CAR_SEQ_STALL_EN.
module car_sequencer
    import car_sequencer_pkg::*;
(
    input  logic          MCLK,
    input  logic          RST_n,
    car_sequencer_if.slave bus
);

    car_t        car_q;
    car_t        car_d;
    car_t        dispatch_car;
    logic [15:0] ir_q;
    logic [15:0] ir_d;
    logic        stall_req;

`ifdef CAR_SEQ_STALL_EN
    assign stall_req = bus.STALL;
`else
    assign stall_req = 1'b0;
`endif

    car_decode u_decode (
        .MDB_in   (bus.MDB_in),
        .SR_flags (bus.SR_flags),
        .next_car (dispatch_car)
    );

    // Next control address and instruction register; everything holds by default.
    always_comb begin
        car_d = car_q;
        ir_d  = ir_q;
        if (!stall_req) begin
            if (is_fetch(car_q)) begin
                if (bus.INTREQ) begin
                    car_d = CAR_INT0;
                end else begin
                    car_d = dispatch_car;
                    ir_d  = bus.MDB_in;
                end
            end else begin
                case (car_q)
                    CAR_REG_IDX0:  car_d = CAR_REG_IDX1;
                    CAR_REG_IDX1:  car_d = CAR_REG_IDX2;
                    CAR_REG_IDX2:  car_d = CAR_REG_IDX3;
                    CAR_IND_REG0:  car_d = CAR_IND_REG1;
                    CAR_IND_IDX0:  car_d = CAR_IND_IDX1;
                    CAR_IND_IDX1:  car_d = CAR_IND_IDX2;
                    CAR_IND_IDX2:  car_d = CAR_IND_IDX3;
                    CAR_IND_IDX3:  car_d = CAR_IND_IDX4;
                    CAR_IDX_REG0:  car_d = CAR_IDX_REG1;
                    CAR_IDX_REG1:  car_d = CAR_IDX_REG2;
                    CAR_IDX_IDX0:  car_d = CAR_IDX_IDX1;
                    CAR_IDX_IDX1:  car_d = CAR_IDX_IDX2;
                    CAR_IDX_IDX2:  car_d = CAR_IDX_IDX3;
                    CAR_IDX_IDX3:  car_d = CAR_IDX_IDX4;
                    CAR_IDX_IDX4:  car_d = CAR_IDX_IDX5;
                    CAR_OP1_IND0:  car_d = CAR_OP1_IND1;
                    CAR_OP1_IND1:  car_d = CAR_OP1_IND2;
                    CAR_OP1_IDX0:  car_d = CAR_OP1_IDX1;
                    CAR_OP1_IDX1:  car_d = CAR_OP1_IDX2;
                    CAR_OP1_IDX2:  car_d = CAR_OP1_IDX3;
                    CAR_PUSH_REG0: car_d = CAR_PUSH_REG1;
                    CAR_PUSH_REG1: car_d = CAR_PUSH_REG2;
                    CAR_PUSH_IND0: car_d = CAR_PUSH_IND1;
                    CAR_PUSH_IND1: car_d = CAR_PUSH_IND2;
                    CAR_PUSH_IDX0: car_d = CAR_PUSH_IDX1;
                    CAR_PUSH_IDX1: car_d = CAR_PUSH_IDX2;
                    CAR_PUSH_IDX2: car_d = CAR_PUSH_IDX3;
                    CAR_CALL_REG0: car_d = CAR_CALL_REG1;
                    CAR_CALL_REG1: car_d = CAR_CALL_REG2;
                    CAR_CALL_IND0: car_d = CAR_CALL_IND1;
                    CAR_CALL_IND1: car_d = CAR_CALL_IND2;
                    CAR_CALL_IDX0: car_d = CAR_CALL_IDX1;
                    CAR_CALL_IDX1: car_d = CAR_CALL_IDX2;
                    CAR_CALL_IDX2: car_d = CAR_CALL_IDX3;
                    CAR_RETI0:     car_d = CAR_RETI1;
                    CAR_RETI1:     car_d = CAR_RETI2;
                    CAR_RETI2:     car_d = CAR_RETI3;
                    CAR_INT0:      car_d = CAR_INT1;
                    CAR_INT1:      car_d = CAR_INT2;
                    CAR_INT2:      car_d = CAR_INT3;
                    CAR_INT3:      car_d = CAR_INT4;
                    default:       car_d = CAR_0;
                endcase
            end
        end
    end

    // CAR/IR registers; reset forces the fetch state with a cleared IR.
    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            car_q <= CAR_0;
            ir_q  <= 16'h0000;
        end else begin
            car_q <= car_d;
            ir_q  <= ir_d;
        end
    end

    assign bus.CAR = car_q;
    assign bus.IR  = ir_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Testbench for car_sequencer: directed vector table, randomized traffic
// against a sequence-list reference model, and hand-written corner cases.
// Build with CAR_SEQ_STALL_EN defined to also exercise the stall input.
module tb_car_sequencer;
    import car_sequencer_pkg::*;

    typedef struct {
        logic [15:0] mdb;
        logic [3:0]  flags;
        logic        intreq;
        car_t        car;
        logic [15:0] ir;
    } vec_t;

    logic MCLK;
    logic RST_n;
    car_sequencer_if bus ();

    car_sequencer dut (
        .MCLK  (MCLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];

    logic [15:0] drv_mdb;
    logic [3:0]  drv_flags;
    logic        drv_int;
    logic        drv_stall;

    car_t        m_car;
    logic [15:0] m_ir;
    car_t        rest[$];
    car_t        nseq[$];

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int mode_of(input logic [1:0] as_f, input logic [3:0] rg);
        if (rg == 4'd3 || (rg == 4'd2 && as_f[1])) return 0;
        if (as_f == 2'b00) return 0;
        if (as_f == 2'b01) return 1;
        return 2;
    endfunction

    function automatic logic cond_ok(input logic [2:0] cc, input logic [3:0] f);
        logic v, n, z, c;
        {v, n, z, c} = f;
        case (cc)
            3'd0: return z == 1'b0;
            3'd1: return z == 1'b1;
            3'd2: return c == 1'b0;
            3'd3: return c == 1'b1;
            3'd4: return n == 1'b1;
            3'd5: return (n ^ v) == 1'b0;
            3'd6: return (n ^ v) == 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void add(input car_t c);
        nseq.push_back(c);
    endfunction

    // Full list of control addresses an instruction word walks through.
    function automatic void build_seq(input logic [15:0] w, input logic [3:0] f);
        int sm;
        logic [3:0] op;
        nseq.delete();
        op = w[15:12];
        if (op >= 4'd4) begin
            sm = mode_of(w[5:4], w[11:8]);
            if (sm == 0 && !w[7]) add(CAR_REG_REG);
            else if (sm == 0) begin add(CAR_REG_IDX0); add(CAR_REG_IDX1); add(CAR_REG_IDX2); add(CAR_REG_IDX3); end
            else if (sm == 2 && !w[7]) begin add(CAR_IND_REG0); add(CAR_IND_REG1); end
            else if (sm == 2) begin add(CAR_IND_IDX0); add(CAR_IND_IDX1); add(CAR_IND_IDX2); add(CAR_IND_IDX3); add(CAR_IND_IDX4); end
            else if (!w[7]) begin add(CAR_IDX_REG0); add(CAR_IDX_REG1); add(CAR_IDX_REG2); end
            else begin add(CAR_IDX_IDX0); add(CAR_IDX_IDX1); add(CAR_IDX_IDX2); add(CAR_IDX_IDX3); add(CAR_IDX_IDX4); add(CAR_IDX_IDX5); end
        end else if (op == 4'd2 || op == 4'd3) begin
            if (cond_ok(w[12:10], f)) add(CAR_JMP0);
            add(CAR_0);
        end else if (op == 4'd1) begin
            sm = mode_of(w[5:4], w[3:0]);
            case (w[9:7])
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    if (sm == 0) add(CAR_OP1_REG);
                    else if (sm == 2) begin add(CAR_OP1_IND0); add(CAR_OP1_IND1); add(CAR_OP1_IND2); end
                    else begin add(CAR_OP1_IDX0); add(CAR_OP1_IDX1); add(CAR_OP1_IDX2); add(CAR_OP1_IDX3); end
                end
                3'd4: begin
                    if (sm == 0) begin add(CAR_PUSH_REG0); add(CAR_PUSH_REG1); add(CAR_PUSH_REG2); end
                    else if (sm == 2) begin add(CAR_PUSH_IND0); add(CAR_PUSH_IND1); add(CAR_PUSH_IND2); end
                    else begin add(CAR_PUSH_IDX0); add(CAR_PUSH_IDX1); add(CAR_PUSH_IDX2); add(CAR_PUSH_IDX3); end
                end
                3'd5: begin
                    if (sm == 0) begin add(CAR_CALL_REG0); add(CAR_CALL_REG1); add(CAR_CALL_REG2); end
                    else if (sm == 2) begin add(CAR_CALL_IND0); add(CAR_CALL_IND1); add(CAR_CALL_IND2); end
                    else begin add(CAR_CALL_IDX0); add(CAR_CALL_IDX1); add(CAR_CALL_IDX2); add(CAR_CALL_IDX3); end
                    add(CAR_0);
                end
                3'd6: begin add(CAR_RETI0); add(CAR_RETI1); add(CAR_RETI2); add(CAR_RETI3); add(CAR_0); end
                default: add(CAR_0);
            endcase
        end else begin
            add(CAR_0);
        end
    endfunction

    // One clock edge of the reference model: an empty remainder means fetch.
    function automatic void model_edge();
        if (drv_stall) return;
        if (rest.size() != 0) begin
            m_car = rest.pop_front();
        end else if (drv_int) begin
            m_car = CAR_INT0;
            rest.delete();
            rest.push_back(CAR_INT1);
            rest.push_back(CAR_INT2);
            rest.push_back(CAR_INT3);
            rest.push_back(CAR_INT4);
            rest.push_back(CAR_0);
        end else begin
            build_seq(drv_mdb, drv_flags);
            m_car = nseq.pop_front();
            rest  = nseq;
            m_ir  = drv_mdb;
        end
    endfunction

    function automatic void model_reset();
        m_car = CAR_0;
        m_ir  = 16'h0000;
        rest.delete();
    endfunction

    task automatic apply_stimulus(input logic [15:0] mdb, input logic [3:0] flags,
                                  input logic intreq, input logic stall);
        drv_mdb   = mdb;
        drv_flags = flags;
        drv_int   = intreq;
`ifdef CAR_SEQ_STALL_EN
        drv_stall = stall;
        bus.STALL = stall;
`else
        drv_stall = 1'b0;
        if (stall) $display("[TB] stall request ignored in this build");
`endif
        bus.MDB_in   = mdb;
        bus.SR_flags = flags;
        bus.INTREQ   = intreq;
        @(posedge MCLK);
        model_edge();
        @(negedge MCLK);
    endtask

    task automatic check_output(input string name, input car_t exp_car, input logic [15:0] exp_ir);
        n_checks++;
        if (bus.CAR !== exp_car || bus.IR !== exp_ir) begin
            $display("[TB] FAIL %s: CAR=%0d IR=%h, expected CAR=%0d IR=%h",
                     name, bus.CAR, bus.IR, exp_car, exp_ir);
        end else begin
            n_pass++;
        end
    endtask

    task automatic pulse_reset(input string name);
        RST_n = 1'b0;
        #2;
        model_reset();
        check_output(name, CAR_0, 16'h0000);
        #1;
        RST_n = 1'b1;
    endtask

    task automatic add_vec(input logic [15:0] mdb, input logic [3:0] flags,
                           input logic intreq, input car_t car, input logic [15:0] ir);
        vec_t v;
        v.mdb = mdb; v.flags = flags; v.intreq = intreq; v.car = car; v.ir = ir;
        vecs.push_back(v);
    endtask

    initial begin
        car_t isr_exp[$];
        RST_n        = 1'b1;
        bus.MDB_in   = 16'h0000;
        bus.SR_flags = 4'h0;
        bus.INTREQ   = 1'b0;
`ifdef CAR_SEQ_STALL_EN
        bus.STALL    = 1'b0;
`endif
        drv_stall = 1'b0;
        model_reset();

        add_vec(16'h4405, 4'h0, 1'b0, CAR_REG_REG,   16'h4405);
        add_vec(16'h5435, 4'h0, 1'b0, CAR_IND_REG0,  16'h5435);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_IND_REG1,  16'h5435);
        add_vec(16'h4485, 4'h0, 1'b0, CAR_REG_IDX0,  16'h4485);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_REG_IDX1,  16'h4485);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_REG_IDX2,  16'h4485);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_REG_IDX3,  16'h4485);
        add_vec(16'h4325, 4'h0, 1'b0, CAR_REG_REG,   16'h4325);
        add_vec(16'h2405, 4'h2, 1'b0, CAR_JMP0,      16'h2405);
        add_vec(16'hFFFF, 4'h2, 1'b0, CAR_0,         16'h2405);
        add_vec(16'h2405, 4'h0, 1'b0, CAR_0,         16'h2405);
        add_vec(16'h3805, 4'h4, 1'b0, CAR_JMP0,      16'h3805);
        add_vec(16'hFFFF, 4'h4, 1'b0, CAR_0,         16'h3805);
        add_vec(16'h1284, 4'h0, 1'b0, CAR_CALL_REG0, 16'h1284);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_CALL_REG1, 16'h1284);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_CALL_REG2, 16'h1284);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_0,         16'h1284);
        add_vec(16'h1300, 4'h0, 1'b0, CAR_RETI0,     16'h1300);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_RETI1,     16'h1300);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_RETI2,     16'h1300);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_RETI3,     16'h1300);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_0,         16'h1300);
        add_vec(16'h0123, 4'h0, 1'b0, CAR_0,         16'h0123);
        add_vec(16'h1380, 4'h0, 1'b0, CAR_0,         16'h1380);
        add_vec(16'h4405, 4'h0, 1'b1, CAR_INT0,      16'h1380);
        add_vec(16'h4405, 4'h0, 1'b1, CAR_INT1,      16'h1380);
        add_vec(16'h4405, 4'h0, 1'b1, CAR_INT2,      16'h1380);
        add_vec(16'h4405, 4'h0, 1'b1, CAR_INT3,      16'h1380);
        add_vec(16'h4405, 4'h0, 1'b1, CAR_INT4,      16'h1380);
        add_vec(16'h4405, 4'h0, 1'b1, CAR_0,         16'h1380);
        add_vec(16'h1224, 4'h0, 1'b0, CAR_PUSH_IND0, 16'h1224);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_PUSH_IND1, 16'h1224);
        add_vec(16'hFFFF, 4'h0, 1'b0, CAR_PUSH_IND2, 16'h1224);

        #1;
        RST_n = 1'b0;
        #2;
        check_output("reset_state", CAR_0, 16'h0000);
        @(negedge MCLK);
        RST_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].mdb, vecs[i].flags, vecs[i].intreq, 1'b0);
            check_output($sformatf("vector_%0d", i), vecs[i].car, vecs[i].ir);
        end

        for (int i = 0; i < 500; i++) begin
            apply_stimulus(16'($urandom), 4'($urandom_range(0, 15)),
                           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            check_output("random", m_car, m_ir);
        end

        pulse_reset("reset_before_int");
        apply_stimulus(16'h4495, 4'h0, 1'b0, 1'b0);
        check_output("idx_idx0", CAR_IDX_IDX0, 16'h4495);
        apply_stimulus(16'hFFFF, 4'h0, 1'b0, 1'b0);
        check_output("idx_idx1", CAR_IDX_IDX1, 16'h4495);
        apply_stimulus(16'hFFFF, 4'h0, 1'b0, 1'b0);
        check_output("idx_idx2", CAR_IDX_IDX2, 16'h4495);
        isr_exp = '{CAR_IDX_IDX3, CAR_IDX_IDX4, CAR_IDX_IDX5, CAR_INT0, CAR_INT1,
                    CAR_INT2, CAR_INT3, CAR_INT4, CAR_0};
        foreach (isr_exp[i]) begin
            apply_stimulus(16'h4405, 4'h0, 1'b1, 1'b0);
            check_output($sformatf("int_seq_%0d", i), isr_exp[i], 16'h4495);
        end
        apply_stimulus(16'h4405, 4'h0, 1'b0, 1'b0);
        check_output("after_int", CAR_REG_REG, 16'h4405);

        apply_stimulus(16'h44A5, 4'h0, 1'b0, 1'b0);
        check_output("ind_idx0", CAR_IND_IDX0, 16'h44A5);
        apply_stimulus(16'hFFFF, 4'h0, 1'b0, 1'b0);
        check_output("ind_idx1", CAR_IND_IDX1, 16'h44A5);
        pulse_reset("reset_mid_ind_idx");
        apply_stimulus(16'h4405, 4'h0, 1'b0, 1'b0);
        check_output("fetch_after_reset", CAR_REG_REG, 16'h4405);

`ifdef CAR_SEQ_STALL_EN
        apply_stimulus(16'h1224, 4'h0, 1'b0, 1'b0);
        check_output("push_ind0", CAR_PUSH_IND0, 16'h1224);
        apply_stimulus(16'hFFFF, 4'h0, 1'b0, 1'b0);
        check_output("push_ind1", CAR_PUSH_IND1, 16'h1224);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(16'hFFFF, 4'h0, 1'b0, 1'b1);
            check_output($sformatf("stall_hold_%0d", i), CAR_PUSH_IND1, 16'h1224);
        end
        apply_stimulus(16'hFFFF, 4'h0, 1'b0, 1'b0);
        check_output("push_ind2", CAR_PUSH_IND2, 16'h1224);
        apply_stimulus(16'h4405, 4'h0, 1'b1, 1'b1);
        check_output("stall_over_int", CAR_PUSH_IND2, 16'h1224);
        apply_stimulus(16'h4405, 4'h0, 1'b1, 1'b0);
        check_output("int_after_stall", CAR_INT0, 16'h1224);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
